// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: resets the PLL, waits for a stable lock, gates the
// measured clock and retries or faults when lock cannot be obtained.
module pll_lock_supervisor #(
   parameter int unsigned RST_HOLD     = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned MAX_RETRY    = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pll_locked,
   input  logic       cnt_clr,
   output logic       pll_rst,
   output logic       clk_valid,
   output logic       fault,
   output logic [7:0] relock_cnt,
   output logic [2:0] state
);

   localparam int unsigned HW = $clog2(RST_HOLD + 1);
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

   localparam logic [HW-1:0] HoldLast   = HW'(RST_HOLD - 1);
   localparam logic [TW-1:0] TimerLast  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] StableLast = SW'(LOCK_STABLE - 1);
   localparam logic [3:0]    RetryMax   = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StReset    = 3'd1,
      StWaitLock = 3'd2,
      StStable   = 3'd3,
      StRun      = 3'd4,
      StFault    = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic          lk_s;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [3:0]    retry_q, retry_d;
   logic [7:0]    relock_q, relock_d;
   logic          pll_rst_q, clk_valid_q, fault_q;

   // pll_locked is asynchronous; only the second synchronizer stage is ever used.
   assign lk_s = sync_q[1];

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      timer_d  = timer_q;
      stab_d   = stab_q;
      retry_d  = retry_q;
      relock_d = relock_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StReset;
               hold_d  = '0;
               retry_d = '0;
            end
            StReset: begin
               if (hold_q == HoldLast) begin
                  state_d = StWaitLock;
                  timer_d = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            StWaitLock: begin
               if (lk_s) begin
                  state_d = StStable;
                  stab_d  = '0;
               end else if (timer_q == TimerLast) begin
                  retry_d = retry_q + 4'd1;
                  hold_d  = '0;
                  state_d = (retry_d == RetryMax) ? StFault : StReset;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            StStable: begin
               if (!lk_s) begin
                  state_d = StWaitLock;
                  timer_d = '0;
               end else if (stab_q == StableLast) begin
                  state_d = StRun;
                  retry_d = '0;
               end else begin
                  stab_d = stab_q + SW'(1);
               end
            end
            StRun: begin
               if (!lk_s) begin
                  state_d = StReset;
                  hold_d  = '0;
                  retry_d = '0;
                  if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
               end
            end
            StFault: ;
            default: state_d = StIdle;
         endcase
      end
      if (cnt_clr) relock_d = '0;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sync_q      <= '0;
         hold_q      <= '0;
         timer_q     <= '0;
         stab_q      <= '0;
         retry_q     <= '0;
         relock_q    <= '0;
         pll_rst_q   <= 1'b1;
         clk_valid_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[0], pll_locked};
         hold_q      <= hold_d;
         timer_q     <= timer_d;
         stab_q      <= stab_d;
         retry_q     <= retry_d;
         relock_q    <= relock_d;
         pll_rst_q   <= (state_d == StIdle) || (state_d == StReset) || (state_d == StFault);
         clk_valid_q <= (state_d == StRun);
         fault_q     <= (state_d == StFault);
      end
   end

   assign pll_rst    = pll_rst_q;
   assign clk_valid  = clk_valid_q;
   assign fault      = fault_q;
   assign relock_cnt = relock_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bench for pll_lock_supervisor against a cycle-level reference model
// built from time-in-state bookkeeping.
module tb_pll_lock_supervisor;
   localparam int RH = 4, LT = 20, LS = 8, MR = 2;
   localparam int M_IDLE = 0, M_RESET = 1, M_WAIT = 2, M_STABLE = 3, M_RUN = 4, M_FAULT = 5;

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0, enable = 1'b0, pll_locked = 1'b0, cnt_clr = 1'b0;
   logic       pll_rst, clk_valid, fault;
   logic [7:0] relock_cnt;
   logic [2:0] state;

   int checks = 0, errors = 0;
   int m_state, m_age, m_retry, m_relock;
   bit m_s1, m_s2;

   pll_lock_supervisor #(
      .RST_HOLD(RH), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked),
      .cnt_clr(cnt_clr), .pll_rst(pll_rst), .clk_valid(clk_valid), .fault(fault),
      .relock_cnt(relock_cnt), .state(state)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = M_IDLE; m_age = 0; m_retry = 0; m_relock = 0; m_s1 = 0; m_s2 = 0;
   endfunction

   function automatic void model_step();
      bit lk = m_s2;
      int nxt = m_state;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      if (!enable) nxt = M_IDLE;
      else case (m_state)
         M_IDLE: begin nxt = M_RESET; m_retry = 0; end
         M_RESET: if (m_age + 1 == RH) nxt = M_WAIT;
         M_WAIT: begin
            if (lk) nxt = M_STABLE;
            else if (m_age + 1 == LT) begin
               m_retry++;
               nxt = (m_retry == MR) ? M_FAULT : M_RESET;
            end
         end
         M_STABLE: begin
            if (!lk) nxt = M_WAIT;
            else if (m_age + 1 == LS) begin nxt = M_RUN; m_retry = 0; end
         end
         M_RUN: if (!lk) begin
            nxt = M_RESET; m_retry = 0;
            if (m_relock < 255) m_relock++;
         end
         default: ;
      endcase
      if (cnt_clr) m_relock = 0;
      m_age = (nxt == m_state) ? m_age + 1 : 0;
      m_state = nxt;
   endfunction

   task automatic compare_all();
      chk("state", state, m_state);
      chk("pll_rst", pll_rst, (m_state == M_IDLE || m_state == M_RESET || m_state == M_FAULT));
      chk("clk_valid", clk_valid, m_state == M_RUN);
      chk("fault", fault, m_state == M_FAULT);
      chk("relock_cnt", relock_cnt, m_relock);
   endtask

   // Inputs change just after a check, i.e. right after the active edge.
   task automatic tick();
      @(posedge refclk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic wait_state(input int s, input int budget);
      int n = 0;
      while (m_state != s && n < budget) begin
         tick();
         n++;
      end
      chk("wait_state", state, s);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_pll_rst"}, pll_rst, 1);
      chk({tag, "_clk_valid"}, clk_valid, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_relock"}, relock_cnt, 0);
   endtask

   initial begin
      int rc;
      int run_left;
      model_reset();
      tick();
      tick();
      chk_reset_values("por");
      rst_n = 1'b1;

      // Bring-up: lock appears 10 cycles after enable.
      enable = 1'b1;
      rc = 0;
      repeat (10) begin
         tick();
         if (state == 3'd1 && pll_rst) rc++;
      end
      chk("rst_hold_cycles", rc, RH);
      pll_locked = 1'b1;
      wait_state(M_RUN, 100);
      chk("bringup_clk_valid", clk_valid, 1);
      chk("bringup_relock", relock_cnt, 0);

      // Lock loss in RUN: clk_valid drops after the third edge.
      pll_locked = 1'b0;
      tick(); tick();
      chk("loss_early_valid", clk_valid, 1);
      tick();
      chk("loss_valid", clk_valid, 0);
      chk("loss_state", state, M_RESET);
      chk("loss_relock", relock_cnt, 1);

      // Lock rising in WAIT_LOCK: STABLE after the third edge.
      wait_state(M_WAIT, 20);
      pll_locked = 1'b1;
      tick(); tick();
      chk("rise_early", state, M_WAIT);
      tick();
      chk("rise_stable", state, M_STABLE);
      wait_state(M_RUN, 50);

      // One-cycle glitch seen while the stable count is 5.
      pll_locked = 1'b0;
      wait_state(M_WAIT, 30);
      pll_locked = 1'b1;
      tick(); tick(); tick();
      chk("glitch_enter", state, M_STABLE);
      tick(); tick(); tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick(); tick();
      chk("glitch_back", state, M_WAIT);
      repeat (8) tick();
      chk("glitch_no_early_run", state, M_STABLE);
      tick();
      chk("glitch_run", state, M_RUN);

      // cnt_clr on the same edge as the relock increment.
      chk("pre_clr_relock", relock_cnt, 2);
      pll_locked = 1'b0;
      tick(); tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_relock", relock_cnt, 0);
      chk("clr_state", state, M_RESET);
      pll_locked = 1'b1;
      wait_state(M_RUN, 50);

      // enable=0 coincident with lock loss in RUN.
      pll_locked = 1'b0;
      tick(); tick();
      enable = 1'b0;
      tick();
      chk("prio_state", state, M_IDLE);
      chk("prio_relock", relock_cnt, 0);

      // Timeout: two attempts of RH+LT cycles, then FAULT.
      tick(); tick();
      enable = 1'b1;
      tick();
      chk("to_first_reset", state, M_RESET);
      repeat (2 * (RH + LT) - 1) tick();
      chk("to_early", state, M_WAIT);
      tick();
      chk("to_fault_state", state, M_FAULT);
      chk("to_fault", fault, 1);
      chk("to_pll_rst", pll_rst, 1);
      pll_locked = 1'b1;
      repeat (5) tick();
      chk("fault_ignores_lock", state, M_FAULT);
      enable = 1'b0;
      tick();
      chk("park_state", state, M_IDLE);
      chk("park_fault", fault, 0);

      // Asynchronous reset pulsed between edges while in WAIT_LOCK.
      pll_locked = 1'b0;
      enable = 1'b1;
      repeat (7) tick();
      chk("pre_areset", state, M_WAIT);
      #3 rst_n = 1'b0;
      #1;
      chk_reset_values("areset");
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      chk("areset_restart", state, M_RESET);

      // 300 relocks saturate the counter.
      pll_locked = 1'b1;
      wait_state(M_RUN, 60);
      repeat (300) begin
         pll_locked = 1'b0;
         repeat (3) tick();
         pll_locked = 1'b1;
         wait_state(M_RUN, 50);
      end
      chk("relock_sat", relock_cnt, 255);

      // Randomized lock runs, occasional park and counter clears.
      run_left = 0;
      repeat (3000) begin
         if (run_left == 0) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            run_left = $urandom_range(1, 40);
         end
         run_left--;
         enable = ($urandom_range(0, 299) != 0);
         cnt_clr = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
